// File: rtl/b2p_pkg.sv
// b2p_pkg: shared definitions for the byte2pixel frame sequencer.
//   state_e      - sequencer state encoding (IDLE/WAIT_FS/ACTIVE/DRAIN)
//   DT_*_DEFAULT - default CSI-2 data types for FS, FE and RAW10 video
//   beat_bytes() - payload bytes carried by one beat of the lane bus
package b2p_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam logic [5:0] DT_FS_DEFAULT  = 6'h00;
  localparam logic [5:0] DT_FE_DEFAULT  = 6'h01;
  localparam logic [5:0] DT_RAW10       = 6'h2B;

  function automatic logic [15:0] beat_bytes(input int num_lane, input int gear);
    return 16'(num_lane * gear / 8);
  endfunction

endpackage

// File: rtl/b2p_pkt_gate.sv
// b2p_pkt_gate: payload gate for one long packet at a time.
//   clk, rst_n      - byte clock, async active-low reset
//   load_i, wc_i    - accepted header and its byte count (wc=0 opens nothing)
//   flush_i         - frame boundary: force the gate closed
//   payload_en_i/payload_i - incoming beats
//   payload_en_o/payload_o - registered forwarded beats; data holds when idle
//   open_o          - gate currently open
module b2p_pkt_gate
  import b2p_pkg::*;
#(
  parameter int NUM_RX_LANE = 4,
  parameter int RX_GEAR     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic [15:0]                   wc_i,
  input  logic                          flush_i,
  input  logic                          payload_en_i,
  input  logic [NUM_RX_LANE*RX_GEAR-1:0] payload_i,
  output logic                          payload_en_o,
  output logic [NUM_RX_LANE*RX_GEAR-1:0] payload_o,
  output logic                          open_o
);

  localparam logic [15:0] BEAT = beat_bytes(NUM_RX_LANE, RX_GEAR);

  logic        open_q;
  logic [15:0] rem_q;

  assign open_o = open_q;

  // NOTE: every flop here uses non-blocking (<=) so each one samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q       <= 1'b0;
      rem_q        <= '0;
      payload_en_o <= 1'b0;
      // NOTE: payload_o is a visible output that must read 0 after reset, so the datapath register is reset too.
      payload_o    <= '0;
    end else begin
      payload_en_o <= 1'b0;
      if (open_q && payload_en_i) begin
        payload_en_o <= 1'b1;
        payload_o    <= payload_i;
        if (rem_q <= BEAT) open_q <= 1'b0;
        else               rem_q  <= rem_q - BEAT;
      end
      // NOTE: the later assignment to open_q wins, so a header arriving with the closing beat reopens the gate.
      if (flush_i) begin
        open_q <= 1'b0;
      end else if (load_i && wc_i != 16'd0) begin
        open_q <= 1'b1;
        rem_q  <= wc_i;
      end
    end
  end

endmodule

// File: rtl/b2p_frame_ctrl.sv
// b2p_frame_ctrl: sequencer between a CSI-2 RX packet parser and byte2pixel.
//   Forwarding starts/stops on FS/FE only; only DT long packets with the
//   expected word count pass; counts lines/frames; sticky error flags.
//   Inputs : clk_byte_i, reset_byte_n_i, enable_i, exp_wc_i, exp_lines_i,
//            err_clr_i, sp_en_i, dt_i, lp_av_en_i, wc_i, payload_en_i, payload_i
//   Outputs: sp_en_o, dt_o, lp_av_en_o, wc_o, payload_en_o, payload_o (1-cycle
//            registered), state_o, frame_cnt_o, line_cnt_o, err_wc_o,
//            err_lines_o, err_seq_o
module b2p_frame_ctrl
  import b2p_pkg::*;
#(
  parameter int         NUM_RX_LANE = 4,
  parameter int         RX_GEAR     = 8,
  parameter logic [5:0] DT          = DT_RAW10,
  parameter logic [5:0] DT_FS       = DT_FS_DEFAULT,
  parameter logic [5:0] DT_FE       = DT_FE_DEFAULT
) (
  input  logic                           clk_byte_i,
  input  logic                           reset_byte_n_i,
  input  logic                           enable_i,
  input  logic [15:0]                    exp_wc_i,
  input  logic [15:0]                    exp_lines_i,
  input  logic                           err_clr_i,
  input  logic                           sp_en_i,
  input  logic [5:0]                     dt_i,
  input  logic                           lp_av_en_i,
  input  logic [15:0]                    wc_i,
  input  logic                           payload_en_i,
  input  logic [NUM_RX_LANE*RX_GEAR-1:0] payload_i,
  output logic                           sp_en_o,
  output logic [5:0]                     dt_o,
  output logic                           lp_av_en_o,
  output logic [15:0]                    wc_o,
  output logic                           payload_en_o,
  output logic [NUM_RX_LANE*RX_GEAR-1:0] payload_o,
  output logic [1:0]                     state_o,
  output logic [15:0]                    frame_cnt_o,
  output logic [15:0]                    line_cnt_o,
  output logic                           err_wc_o,
  output logic                           err_lines_o,
  output logic                           err_seq_o
);

  state_e      state_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] line_cnt_q;
  logic        err_wc_q, err_lines_q, err_seq_q;

  // Packet decode, qualified by the state the packet arrives in.
  logic in_frame, is_fs, is_fe, fs_start, fs_seq, fe_end, sp_fwd;
  logic lp_video, lp_ok, lp_bad, gate_flush, gate_open;

  assign in_frame   = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign is_fs      = sp_en_i && (dt_i == DT_FS);
  assign is_fe      = sp_en_i && (dt_i == DT_FE);
  assign fs_start   = (state_q == ST_WAIT_FS) && enable_i && is_fs;
  assign fs_seq     = in_frame && is_fs;
  assign fe_end     = in_frame && is_fe;
  assign sp_fwd     = fs_start || (in_frame && sp_en_i);
  assign lp_video   = in_frame && lp_av_en_i && (dt_i == DT);
  assign lp_ok      = lp_video && (wc_i == exp_wc_i);
  assign lp_bad     = lp_video && (wc_i != exp_wc_i);
  // Any frame boundary closes a gate left open by a truncated packet.
  assign gate_flush = fs_start || fs_seq || fe_end;

  b2p_pkt_gate #(
    .NUM_RX_LANE (NUM_RX_LANE),
    .RX_GEAR     (RX_GEAR)
  ) u_gate (
    .clk          (clk_byte_i),
    .rst_n        (reset_byte_n_i),
    .load_i       (lp_ok),
    .wc_i         (wc_i),
    .flush_i      (gate_flush),
    .payload_en_i (payload_en_i),
    .payload_i    (payload_i),
    .payload_en_o (payload_en_o),
    .payload_o    (payload_o),
    .open_o       (gate_open)
  );

  always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
    if (!reset_byte_n_i) begin
      state_q     <= ST_IDLE;
      sp_en_o     <= 1'b0;
      dt_o        <= '0;
      lp_av_en_o  <= 1'b0;
      wc_o        <= '0;
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
      err_wc_q    <= 1'b0;
      err_lines_q <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      sp_en_o    <= sp_fwd;
      lp_av_en_o <= lp_ok;
      if (sp_fwd || lp_ok) dt_o <= dt_i;
      if (lp_ok)           wc_o <= wc_i;

      // Written every cycle so the count is always a pure function of the last value.
      frame_cnt_q <= frame_cnt_q + 16'(fe_end);

      if (fs_start || fs_seq)                   line_cnt_q <= '0;
      else if (lp_ok && line_cnt_q != 16'hFFFF) line_cnt_q <= line_cnt_q + 16'd1;

      // Set events take priority over a simultaneous clear.
      err_wc_q    <= lp_bad | (err_wc_q & ~err_clr_i);
      err_lines_q <= (fe_end && line_cnt_q != exp_lines_i) | (err_lines_q & ~err_clr_i);
      err_seq_q   <= fs_seq | (err_seq_q & ~err_clr_i);

      case (state_q)
        ST_IDLE:    if (enable_i) state_q <= ST_WAIT_FS;
        ST_WAIT_FS: begin
          if (!enable_i)  state_q <= ST_IDLE;
          else if (is_fs) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (fe_end)         state_q <= enable_i ? ST_WAIT_FS : ST_IDLE;
          else if (!enable_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN:   if (fe_end) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o     = state_q;
  assign frame_cnt_o = frame_cnt_q;
  assign line_cnt_o  = line_cnt_q;
  assign err_wc_o    = err_wc_q;
  assign err_lines_o = err_lines_q;
  assign err_seq_o   = err_seq_q;

endmodule

// File: tb/tb_b2p_frame_ctrl.sv
// tb_b2p_frame_ctrl: directed self-checking bench for b2p_frame_ctrl
// (4 lanes x gear 8, 4 bytes per beat).
module tb_b2p_frame_ctrl;

  localparam int PW = 32;
  localparam logic [5:0] FS = 6'h00, FE = 6'h01, VID = 6'h2B, EMB = 6'h12;

  logic          clk_byte_i = 1'b0;
  logic          reset_byte_n_i = 1'b1;
  logic          enable_i = 1'b0;
  logic [15:0]   exp_wc_i = 16'd1280;
  logic [15:0]   exp_lines_i = 16'd4;
  logic          err_clr_i = 1'b0;
  logic          sp_en_i = 1'b0;
  logic [5:0]    dt_i = '0;
  logic          lp_av_en_i = 1'b0;
  logic [15:0]   wc_i = '0;
  logic          payload_en_i = 1'b0;
  logic [PW-1:0] payload_i = '0;
  logic          sp_en_o, lp_av_en_o, payload_en_o;
  logic [5:0]    dt_o;
  logic [15:0]   wc_o, frame_cnt_o, line_cnt_o;
  logic [PW-1:0] payload_o;
  logic [1:0]    state_o;
  logic          err_wc_o, err_lines_o, err_seq_o;

  int n_cmp = 0;
  int n_fail = 0;

  b2p_frame_ctrl dut (
    .clk_byte_i     (clk_byte_i),
    .reset_byte_n_i (reset_byte_n_i),
    .enable_i       (enable_i),
    .exp_wc_i       (exp_wc_i),
    .exp_lines_i    (exp_lines_i),
    .err_clr_i      (err_clr_i),
    .sp_en_i        (sp_en_i),
    .dt_i           (dt_i),
    .lp_av_en_i     (lp_av_en_i),
    .wc_i           (wc_i),
    .payload_en_i   (payload_en_i),
    .payload_i      (payload_i),
    .sp_en_o        (sp_en_o),
    .dt_o           (dt_o),
    .lp_av_en_o     (lp_av_en_o),
    .wc_o           (wc_o),
    .payload_en_o   (payload_en_o),
    .payload_o      (payload_o),
    .state_o        (state_o),
    .frame_cnt_o    (frame_cnt_o),
    .line_cnt_o     (line_cnt_o),
    .err_wc_o       (err_wc_o),
    .err_lines_o    (err_lines_o),
    .err_seq_o      (err_seq_o)
  );

  always #5 clk_byte_i = ~clk_byte_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic cyc();
    @(posedge clk_byte_i);
    #1;
  endtask

  task automatic sp(input logic [5:0] d);
    sp_en_i = 1'b1; dt_i = d;
    cyc();
    sp_en_i = 1'b0;
  endtask

  task automatic hdr(input logic [5:0] d, input logic [15:0] w);
    lp_av_en_i = 1'b1; dt_i = d; wc_i = w;
    cyc();
    lp_av_en_i = 1'b0;
  endtask

  // One long packet: header then 'beats' payload beats; reports what was forwarded.
  task automatic line(input logic [5:0] d, input logic [15:0] w, input int beats,
                      output logic hdr_fwd, output int fwd, output int bad);
    logic [PW-1:0] word;
    hdr(d, w);
    hdr_fwd = lp_av_en_o;
    fwd = 0; bad = 0;
    for (int i = 0; i < beats; i++) begin
      word = $urandom;
      payload_en_i = 1'b1; payload_i = word;
      cyc();
      if (payload_en_o) begin
        fwd++;
        if (payload_o !== word) bad++;
      end
    end
    payload_en_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_frames"}, frame_cnt_o, 0);
    chk({tag, "_lines"}, line_cnt_o, 0);
    chk({tag, "_strobes"}, {sp_en_o, lp_av_en_o, payload_en_o}, 0);
    chk({tag, "_dt_wc"}, {dt_o, wc_o}, 0);
    chk({tag, "_payload"}, payload_o, 0);
    chk({tag, "_errs"}, {err_wc_o, err_lines_o, err_seq_o}, 0);
  endtask

  initial begin
    logic hf;
    int   fw, bd;

    // Reset state
    #1 reset_byte_n_i = 1'b0;
    #3 chk_all_zero("rst");
    @(negedge clk_byte_i);
    reset_byte_n_i = 1'b1;
    cyc();

    // 1) Normal frame: 4 lines of 1280 bytes
    enable_i = 1'b1;
    cyc();
    chk("t1_wait_fs", state_o, 1);
    sp_en_i = 1'b1; dt_i = FS;
    chk("t1_fs_not_early", sp_en_o, 0);
    cyc();
    sp_en_i = 1'b0;
    chk("t1_fs_fwd", {sp_en_o, dt_o}, {1'b1, FS});
    chk("t1_active", state_o, 2);
    cyc();
    chk("t1_fs_one_cycle", sp_en_o, 0);
    for (int l = 0; l < 4; l++) begin
      line(VID, 16'd1280, 320, hf, fw, bd);
      chk("t1_hdr_fwd", hf, 1);
      chk("t1_beats", fw, 320);
      chk("t1_data", bd, 0);
    end
    chk("t1_wc_o", wc_o, 1280);
    payload_en_i = 1'b1;
    cyc();
    payload_en_i = 1'b0;
    chk("t1_gate_closed", payload_en_o, 0);
    chk("t1_line_cnt", line_cnt_o, 4);
    sp(FE);
    chk("t1_fe_fwd", {sp_en_o, dt_o}, {1'b1, FE});
    chk("t1_frames", frame_cnt_o, 1);
    chk("t1_errs", {err_wc_o, err_lines_o, err_seq_o}, 0);
    chk("t1_back_wait", state_o, 1);
    cyc();
    chk("t1_dt_hold", {sp_en_o, dt_o}, {1'b0, FE});

    // 2) Enable raised mid-frame: nothing until next FS, FE not counted
    enable_i = 1'b0;
    cyc();
    chk("t2_idle", state_o, 0);
    sp(FS);
    chk("t2_fs_dropped", sp_en_o, 0);
    enable_i = 1'b1;
    cyc();
    chk("t2_wait", state_o, 1);
    line(VID, 16'd1280, 320, hf, fw, bd);
    chk("t2_hdr_blocked", hf, 0);
    chk("t2_beats_blocked", fw, 0);
    sp(FE);
    chk("t2_fe_blocked", sp_en_o, 0);
    chk("t2_frames", frame_cnt_o, 1);
    chk("t2_dt_hold", dt_o, FE);

    // 3) Wrong word count on line 2
    sp(FS);
    chk("t3_active", state_o, 2);
    line(VID, 16'd1280, 320, hf, fw, bd);
    chk("t3_l1_beats", fw, 320);
    line(VID, 16'd1276, 319, hf, fw, bd);
    chk("t3_bad_hdr", hf, 0);
    chk("t3_bad_beats", fw, 0);
    chk("t3_err_wc", err_wc_o, 1);
    for (int l = 0; l < 2; l++) begin
      line(VID, 16'd1280, 320, hf, fw, bd);
      chk("t3_beats", fw, 320);
    end
    sp(FE);
    chk("t3_line_cnt", line_cnt_o, 3);
    chk("t3_err_lines", err_lines_o, 1);
    chk("t3_frames", frame_cnt_o, 2);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    chk("t3_cleared", {err_wc_o, err_lines_o, err_seq_o}, 0);

    // 4) Embedded-data line ignored, then FS without FE
    sp(FS);
    line(VID, 16'd1280, 320, hf, fw, bd);
    line(EMB, 16'd1280, 320, hf, fw, bd);
    chk("t4_emb_hdr", hf, 0);
    chk("t4_emb_beats", fw, 0);
    chk("t4_emb_lines", line_cnt_o, 1);
    chk("t4_dt_hold", dt_o, VID);
    sp(FS);
    chk("t4_fs_fwd", sp_en_o, 1);
    chk("t4_err_seq", err_seq_o, 1);
    chk("t4_line_reset", line_cnt_o, 0);
    chk("t4_still_active", state_o, 2);
    chk("t4_frames", frame_cnt_o, 2);

    // 5) Enable dropped after line 1 -> DRAIN
    line(VID, 16'd1280, 320, hf, fw, bd);
    enable_i = 1'b0;
    cyc();
    chk("t5_drain", state_o, 3);
    enable_i = 1'b1;
    line(VID, 16'd1280, 320, hf, fw, bd);
    chk("t5_drain_hdr", hf, 1);
    chk("t5_drain_beats", fw, 320);
    chk("t5_drain_held", state_o, 3);
    enable_i = 1'b0;
    sp(FE);
    chk("t5_fe_fwd", sp_en_o, 1);
    chk("t5_idle", state_o, 0);
    chk("t5_frames", frame_cnt_o, 3);
    chk("t5_err_lines", err_lines_o, 1);
    sp(FS);
    chk("t5_fs_dropped", sp_en_o, 0);
    chk("t5_still_idle", state_o, 0);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    chk("t5_cleared", {err_wc_o, err_lines_o, err_seq_o}, 0);

    // 6) Closing beat + header, wc=0, clear vs set, frame counter wrap
    enable_i = 1'b1;
    cyc();
    sp(FS);
    exp_wc_i = 16'd10;
    hdr(VID, 16'd10);
    chk("t6_hdr10", {lp_av_en_o, wc_o}, {1'b1, 16'd10});
    payload_en_i = 1'b1;
    cyc();
    cyc();
    lp_av_en_i = 1'b1; dt_i = VID; wc_i = 16'd10;
    cyc();
    lp_av_en_i = 1'b0;
    chk("t6_close_beat", payload_en_o, 1);
    chk("t6_close_hdr", lp_av_en_o, 1);
    fw = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (payload_en_o) fw++;
    end
    payload_en_i = 1'b0;
    chk("t6_second_pkt_beats", fw, 3);
    exp_wc_i = 16'd0;
    hdr(VID, 16'd0);
    chk("t6_wc0_fwd", lp_av_en_o, 1);
    chk("t6_wc0_lines", line_cnt_o, 3);
    payload_en_i = 1'b1;
    cyc();
    payload_en_i = 1'b0;
    chk("t6_wc0_no_gate", payload_en_o, 0);
    err_clr_i = 1'b1;
    hdr(VID, 16'd7);
    err_clr_i = 1'b0;
    chk("t6_set_wins", err_wc_o, 1);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    chk("t6_clear", err_wc_o, 0);
    force dut.frame_cnt_q = 16'hFFFF;
    cyc();
    release dut.frame_cnt_q;
    chk("t6_preload", frame_cnt_o, 16'hFFFF);
    sp(FE);
    chk("t6_wrap", frame_cnt_o, 0);
    chk("t6_wait", state_o, 1);

    // 7) Asynchronous reset during payload
    exp_wc_i = 16'd1280;
    sp(FS);
    hdr(VID, 16'd1280);
    payload_en_i = 1'b1; payload_i = 32'hDEADBEEF;
    cyc();
    chk("t7_beat_fwd", payload_en_o, 1);
    #1 reset_byte_n_i = 1'b0;
    #1 chk_all_zero("t7_rst");
    @(negedge clk_byte_i);
    reset_byte_n_i = 1'b1;
    cyc();
    chk("t7_wait_fs", state_o, 1);
    chk("t7_payload_blocked", payload_en_o, 0);
    payload_en_i = 1'b0;
    sp(FS);
    chk("t7_resume", {sp_en_o, state_o}, {1'b1, 2'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
